bram_arbiter: RTL and testbench

- Two-requester arbiter in front of one synchronous single-port block RAM (1-cycle read latency, write-first read-back) in the RV32I embedded softcore.
- Lets instruction fetch (port 0) and load/store (port 1) share one BRAM instance.
- Grants at most one access per cycle and routes each response back to its originator.
- Supports round-robin arbitration, or fixed priority with a starvation bound.

---
 rtl/bram_arbiter_pkg.sv | 12 +
 rtl/bram_arbiter.sv | 137 +++++++++++++
 tb/tb_bram_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared constants for the BRAM arbiter: arbitration modes and port indices.
package bram_arbiter_pkg;

    localparam int unsigned ARB_RR   = 0;
    localparam int unsigned ARB_PRIO = 1;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

    localparam int unsigned BURST_CNT_W = 4;

endpackage

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous BRAM (1-cycle read latency).
// Port 0 is instruction fetch, port 1 is load/store. Grants are combinational in the
// request cycle; the response is steered back to its owner the following cycle.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH_LOG = 8,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ARB_MODE  = ARB_RR,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [DEPTH_LOG-1:0] p0_addr,
    input  logic [WIDTH-1:0]     p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    output logic [WIDTH-1:0]     p0_rdata,

    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [DEPTH_LOG-1:0] p1_addr,
    input  logic [WIDTH-1:0]     p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic [WIDTH-1:0]     p1_rdata,

    output logic                 mem_en,
    output logic                 mem_we,
    output logic [DEPTH_LOG-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_di,
    input  logic [WIDTH-1:0]     mem_do
);

    localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

    logic                   last_win_q,   last_win_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q,  burst_cnt_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_owner_q, resp_owner_d;

    logic                   p0_win;
    logic                   p1_win;

    // Pick the winner; a tie is resolved by round-robin or by bounded fixed priority.
    always_comb begin
        p0_win = 1'b0;
        p1_win = 1'b0;
        if (p0_req && !p1_req) begin
            p0_win = 1'b1;
        end else if (p1_req && !p0_req) begin
            p1_win = 1'b1;
        end else if (p0_req && p1_req) begin
            if (ARB_MODE == ARB_PRIO) begin
                if (burst_cnt_q == MAX_CNT) begin
                    p1_win = 1'b1;
                end else begin
                    p0_win = 1'b1;
                end
            end else begin
                if (last_win_q == PORT_LSU) begin
                    p0_win = 1'b1;
                end else begin
                    p1_win = 1'b1;
                end
            end
        end
    end

    // Grants are suppressed while reset is held so no access starts during reset.
    always_comb begin
        p0_gnt = p0_win & ~reset;
        p1_gnt = p1_win & ~reset;
    end

    // Route the winner's fields to the BRAM; port 0 fields are parked there when idle.
    always_comb begin
        mem_en   = p0_gnt | p1_gnt;
        mem_we   = 1'b0;
        mem_addr = p0_addr;
        mem_di   = p0_wdata;
        if (p1_gnt) begin
            mem_we   = p1_we;
            mem_addr = p1_addr;
            mem_di   = p1_wdata;
        end else if (p0_gnt) begin
            mem_we   = p0_we;
        end
    end

    // Next-state for arbitration history and the response pipeline stage.
    always_comb begin
        last_win_d   = last_win_q;
        burst_cnt_d  = burst_cnt_q;
        resp_valid_d = p0_gnt | p1_gnt;
        resp_owner_d = p1_gnt ? PORT_LSU : PORT_IFETCH;

        if (p1_gnt) begin
            last_win_d = PORT_LSU;
        end else if (p0_gnt) begin
            last_win_d = PORT_IFETCH;
        end

        if (!p1_req || p1_gnt) begin
            burst_cnt_d = '0;
        end else if (p0_gnt && (burst_cnt_q != MAX_CNT)) begin
            burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_win_q   <= PORT_LSU;
            burst_cnt_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= PORT_IFETCH;
        end else begin
            last_win_q   <= last_win_d;
            burst_cnt_q  <= burst_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    // Steer the BRAM output back to whichever port owned last cycle's access.
    always_comb begin
        p0_rvalid = resp_valid_q & (resp_owner_q == PORT_IFETCH);
        p1_rvalid = resp_valid_q & (resp_owner_q == PORT_LSU);
        p0_rdata  = mem_do;
        p1_rdata  = mem_do;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: one round-robin and one fixed-priority instance, each with a
// behavioural write-first BRAM; expected responses are queued at grant time.
module tb_bram_arbiter;
    import bram_arbiter_pkg::*;

    localparam int unsigned DL = 8;
    localparam int unsigned W  = 32;
    localparam int unsigned MB = 4;

    typedef struct packed {
        logic        port;
        logic [W-1:0] data;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Round-robin instance signals
    logic          r_p0_req, r_p0_we, r_p0_gnt, r_p0_rvalid;
    logic [DL-1:0] r_p0_addr;
    logic [W-1:0]  r_p0_wdata, r_p0_rdata;
    logic          r_p1_req, r_p1_we, r_p1_gnt, r_p1_rvalid;
    logic [DL-1:0] r_p1_addr;
    logic [W-1:0]  r_p1_wdata, r_p1_rdata;
    logic          r_mem_en, r_mem_we;
    logic [DL-1:0] r_mem_addr;
    logic [W-1:0]  r_mem_di, r_mem_do;

    // Fixed-priority instance signals
    logic          f_p0_req, f_p0_we, f_p0_gnt, f_p0_rvalid;
    logic [DL-1:0] f_p0_addr;
    logic [W-1:0]  f_p0_wdata, f_p0_rdata;
    logic          f_p1_req, f_p1_we, f_p1_gnt, f_p1_rvalid;
    logic [DL-1:0] f_p1_addr;
    logic [W-1:0]  f_p1_wdata, f_p1_rdata;
    logic          f_mem_en, f_mem_we;
    logic [DL-1:0] f_mem_addr;
    logic [W-1:0]  f_mem_di, f_mem_do;

    bram_arbiter #(.DEPTH_LOG(DL), .WIDTH(W), .ARB_MODE(ARB_RR), .MAX_BURST(MB)) u_rr (
        .clk(clk), .reset(reset),
        .p0_req(r_p0_req), .p0_we(r_p0_we), .p0_addr(r_p0_addr), .p0_wdata(r_p0_wdata),
        .p0_gnt(r_p0_gnt), .p0_rvalid(r_p0_rvalid), .p0_rdata(r_p0_rdata),
        .p1_req(r_p1_req), .p1_we(r_p1_we), .p1_addr(r_p1_addr), .p1_wdata(r_p1_wdata),
        .p1_gnt(r_p1_gnt), .p1_rvalid(r_p1_rvalid), .p1_rdata(r_p1_rdata),
        .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_di(r_mem_di),
        .mem_do(r_mem_do)
    );

    bram_arbiter #(.DEPTH_LOG(DL), .WIDTH(W), .ARB_MODE(ARB_PRIO), .MAX_BURST(MB)) u_pr (
        .clk(clk), .reset(reset),
        .p0_req(f_p0_req), .p0_we(f_p0_we), .p0_addr(f_p0_addr), .p0_wdata(f_p0_wdata),
        .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
        .p1_req(f_p1_req), .p1_we(f_p1_we), .p1_addr(f_p1_addr), .p1_wdata(f_p1_wdata),
        .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_di(f_mem_di),
        .mem_do(f_mem_do)
    );

    // Behavioural single-port write-first BRAMs
    logic [W-1:0] r_ram [0:(1<<DL)-1];
    logic [W-1:0] f_ram [0:(1<<DL)-1];
    logic [W-1:0] r_ref [0:(1<<DL)-1];
    logic [W-1:0] f_ref [0:(1<<DL)-1];

    always @(posedge clk) begin
        if (r_mem_en) begin
            if (r_mem_we) begin
                r_ram[r_mem_addr] <= r_mem_di;
                r_mem_do <= r_mem_di;
            end else begin
                r_mem_do <= r_ram[r_mem_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (f_mem_en) begin
            if (f_mem_we) begin
                f_ram[f_mem_addr] <= f_mem_di;
                f_mem_do <= f_mem_di;
            end else begin
                f_mem_do <= f_ram[f_mem_addr];
            end
        end
    end

    exp_t r_q[$];
    exp_t f_q[$];
    exp_t r_e;
    exp_t f_e;
    logic rr_last = 1'b1;
    int unsigned f_cnt = 0;

    // Response scoreboard, round-robin instance
    always @(negedge clk) begin
        if (!reset) begin
            if (r_q.size() > 0 && r_q[0].due == cyc) begin
                r_e = r_q.pop_front();
                checks++;
                if (r_p0_rvalid !== ~r_e.port || r_p1_rvalid !== r_e.port ||
                    (r_e.port ? r_p1_rdata : r_p0_rdata) !== r_e.data) begin
                    errors++;
                    $display("FAIL rr_resp cyc=%0d got rv0=%b rv1=%b d0=%h d1=%h want port%0d data=%h",
                             cyc, r_p0_rvalid, r_p1_rvalid, r_p0_rdata, r_p1_rdata, r_e.port, r_e.data);
                end
            end else if (r_p0_rvalid !== 1'b0 || r_p1_rvalid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL rr_spurious cyc=%0d got rv0=%b rv1=%b want 0 0", cyc, r_p0_rvalid, r_p1_rvalid);
            end
        end
    end

    // Response scoreboard, fixed-priority instance
    always @(negedge clk) begin
        if (!reset) begin
            if (f_q.size() > 0 && f_q[0].due == cyc) begin
                f_e = f_q.pop_front();
                checks++;
                if (f_p0_rvalid !== ~f_e.port || f_p1_rvalid !== f_e.port ||
                    (f_e.port ? f_p1_rdata : f_p0_rdata) !== f_e.data) begin
                    errors++;
                    $display("FAIL pr_resp cyc=%0d got rv0=%b rv1=%b d0=%h d1=%h want port%0d data=%h",
                             cyc, f_p0_rvalid, f_p1_rvalid, f_p0_rdata, f_p1_rdata, f_e.port, f_e.data);
                end
            end else if (f_p0_rvalid !== 1'b0 || f_p1_rvalid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL pr_spurious cyc=%0d got rv0=%b rv1=%b want 0 0", cyc, f_p0_rvalid, f_p1_rvalid);
            end
        end
    end

    task automatic r_drive(input logic q0, input logic we0, input logic [DL-1:0] a0, input logic [W-1:0] d0,
                           input logic q1, input logic we1, input logic [DL-1:0] a1, input logic [W-1:0] d1);
        r_p0_req = q0; r_p0_we = we0; r_p0_addr = a0; r_p0_wdata = d0;
        r_p1_req = q1; r_p1_we = we1; r_p1_addr = a1; r_p1_wdata = d1;
    endtask

    task automatic f_drive(input logic q0, input logic [DL-1:0] a0, input logic q1, input logic [DL-1:0] a1);
        f_p0_req = q0; f_p0_we = 1'b0; f_p0_addr = a0; f_p0_wdata = '0;
        f_p1_req = q1; f_p1_we = 1'b0; f_p1_addr = a1; f_p1_wdata = '0;
    endtask

    // Queue the expected response of a round-robin grant and update the reference memory
    task automatic r_push(input logic port, input logic we, input logic [DL-1:0] a, input logic [W-1:0] d);
        exp_t e;
        e.port = port;
        e.due  = cyc + 1;
        if (we) begin
            r_ref[a] = d;
            e.data = d;
        end else begin
            e.data = r_ref[a];
        end
        r_q.push_back(e);
        rr_last = port;
    endtask

    task automatic test_reset();
        r_drive(1'b1, 1'b1, 8'h05, 32'h0BAD0BAD, 1'b1, 1'b1, 8'h06, 32'h0BAD0BAD);
        f_drive(1'b1, 8'h05, 1'b1, 8'h06);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({r_p0_gnt, r_p1_gnt, r_mem_en, r_mem_we, r_p0_rvalid, r_p1_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_rr got gnt=%b%b en=%b we=%b rv=%b%b want all 0",
                     r_p0_gnt, r_p1_gnt, r_mem_en, r_mem_we, r_p0_rvalid, r_p1_rvalid);
        end
        checks++;
        if ({f_p0_gnt, f_p1_gnt, f_mem_en, f_mem_we, f_p0_rvalid, f_p1_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pr got gnt=%b%b en=%b we=%b rv=%b%b want all 0",
                     f_p0_gnt, f_p1_gnt, f_mem_en, f_mem_we, f_p0_rvalid, f_p1_rvalid);
        end
        @(posedge clk); #1;
        r_drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        f_drive(1'b0, '0, 1'b0, '0);
        reset = 1'b0;
        rr_last = 1'b1;
        f_cnt = 0;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        r_drive(1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0, 8'h77, '0);
        @(negedge clk);
        checks++;
        if (r_p0_gnt !== 1'b1 || r_p1_gnt !== 1'b0 || r_mem_en !== 1'b1 || r_mem_we !== 1'b0 ||
            r_mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL single_read_gnt got gnt=%b%b en=%b we=%b addr=%h want 10 1 0 10",
                     r_p0_gnt, r_p1_gnt, r_mem_en, r_mem_we, r_mem_addr);
        end
        r_push(1'b0, 1'b0, 8'h10, '0);
        @(posedge clk); #1;
        r_drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (r_p0_rdata !== 32'hDEADBEEF || r_p0_rvalid !== 1'b1 || r_p1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_read_data got rv=%b%b data=%h want 1 0 deadbeef",
                     r_p0_rvalid, r_p1_rvalid, r_p0_rdata);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        r_drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h20, 32'h12345678);
        @(negedge clk);
        checks++;
        if (r_p1_gnt !== 1'b1 || r_p0_gnt !== 1'b0 || r_mem_we !== 1'b1 || r_mem_di !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_write_gnt got gnt=%b%b we=%b di=%h want 01 1 12345678",
                     r_p0_gnt, r_p1_gnt, r_mem_we, r_mem_di);
        end
        r_push(1'b1, 1'b1, 8'h20, 32'h12345678);
        @(posedge clk); #1;
        r_drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h20, '0);
        @(negedge clk);
        checks++;
        if (r_p1_gnt !== 1'b1 || r_mem_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read_gnt got gnt1=%b we=%b want 1 0", r_p1_gnt, r_mem_we);
        end
        r_push(1'b1, 1'b0, 8'h20, '0);
        @(posedge clk); #1;
        r_drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [DL-1:0] a0 = 8'h40;
        logic [DL-1:0] a1 = 8'h80;
        logic ew;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            r_drive(1'b1, 1'b0, a0, '0, 1'b1, 1'b0, a1, '0);
            @(negedge clk);
            ew = ~rr_last;
            checks++;
            if (r_p0_gnt !== ~ew || r_p1_gnt !== ew || ew !== 1'(i % 2)) begin
                errors++;
                $display("FAIL rr_gnt i=%0d got gnt=%b%b want winner port%0d", i, r_p0_gnt, r_p1_gnt, ew);
            end
            if (ew) begin
                r_push(1'b1, 1'b0, a1, '0);
                a1 = a1 + 8'd1;
            end else begin
                r_push(1'b0, 1'b0, a0, '0);
                a0 = a0 + 8'd1;
            end
        end
        @(posedge clk); #1;
        r_drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        logic [DL-1:0] a0 = 8'h30;
        logic [DL-1:0] a1 = 8'hC0;
        logic q1;
        logic ew;
        exp_t e;
        int wait1 = 0;
        int max_wait = 0;
        for (int i = 0; i < 14; i++) begin
            q1 = (i < 10 || i >= 12);
            @(posedge clk); #1;
            f_drive(1'b1, a0, q1, a1);
            @(negedge clk);
            ew = q1 && (f_cnt == MB);
            checks++;
            if (f_p0_gnt !== ~ew || f_p1_gnt !== ew) begin
                errors++;
                $display("FAIL prio_gnt i=%0d got gnt=%b%b want winner port%0d cnt=%0d",
                         i, f_p0_gnt, f_p1_gnt, ew, f_cnt);
            end
            if (q1 && !f_p1_gnt) wait1++;
            else wait1 = 0;
            if (wait1 > max_wait) max_wait = wait1;
            e.port = ew;
            e.due  = cyc + 1;
            e.data = ew ? f_ref[a1] : f_ref[a0];
            f_q.push_back(e);
            if (ew) a1 = a1 + 8'd1;
            else a0 = a0 + 8'd1;
            if (!q1 || ew) f_cnt = 0;
            else if (f_cnt != MB) f_cnt++;
        end
        @(posedge clk); #1;
        f_drive(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (max_wait + 1 > MB + 1) begin
            errors++;
            $display("FAIL prio_starve got wait=%0d cycles want <= %0d", max_wait + 1, MB + 1);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        r_drive(1'b1, 1'b0, 8'h11, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (r_p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_gnt got gnt0=%b want 1", r_p0_gnt);
        end
        @(posedge clk); #1;
        r_q.delete();
        f_q.delete();
        reset = 1'b1;
        r_drive(1'b1, 1'b0, 8'h12, '0, 1'b1, 1'b0, 8'h13, '0);
        #1;
        checks++;
        if (r_p0_rvalid !== 1'b0 || r_p1_rvalid !== 1'b0 || r_p0_gnt !== 1'b0 || r_p1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_kill got rv=%b%b gnt=%b%b want 00 00",
                     r_p0_rvalid, r_p1_rvalid, r_p0_gnt, r_p1_gnt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rr_last = 1'b1;
        f_cnt = 0;
        @(negedge clk);
        checks++;
        if (r_p0_gnt !== 1'b1 || r_p1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_first got gnt=%b%b want 10", r_p0_gnt, r_p1_gnt);
        end
        r_push(1'b0, 1'b0, 8'h12, '0);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (r_p1_gnt !== 1'b1 || r_p0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_second got gnt=%b%b want 01", r_p0_gnt, r_p1_gnt);
        end
        r_push(1'b1, 1'b0, 8'h13, '0);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            r_drive(1'b0, 1'b0, 8'h5A, 32'hCAFEF00D, 1'b0, 1'b1, 8'hA5, '0);
            @(negedge clk);
            checks++;
            if (r_mem_en !== 1'b0 || r_mem_we !== 1'b0 || r_p0_gnt !== 1'b0 || r_p1_gnt !== 1'b0 ||
                r_mem_addr !== 8'h5A || r_mem_di !== 32'hCAFEF00D) begin
                errors++;
                $display("FAIL idle_mem i=%0d got en=%b we=%b gnt=%b%b addr=%h di=%h want 0 0 00 5a cafef00d",
                         i, r_mem_en, r_mem_we, r_p0_gnt, r_p1_gnt, r_mem_addr, r_mem_di);
            end
            if (i > 0) begin
                checks++;
                if (r_p0_rvalid !== 1'b0 || r_p1_rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_rvalid i=%0d got rv=%b%b want 00", i, r_p0_rvalid, r_p1_rvalid);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << DL); i++) begin
            r_ram[i] = 32'hA5000000 | W'(i);
            f_ram[i] = 32'h5A000000 | W'(i);
            r_ref[i] = 32'hA5000000 | W'(i);
            f_ref[i] = 32'h5A000000 | W'(i);
        end
        r_ram[8'h10] = 32'hDEADBEEF;
        r_ref[8'h10] = 32'hDEADBEEF;

        test_reset();
        test_single_read();
        test_back_to_back();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid();
        test_idle();

        repeat (2) @(negedge clk);
        checks++;
        if (r_q.size() != 0 || f_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got rr=%0d pr=%0d pending want 0 0", r_q.size(), f_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
